// File: rtl/xentry_pkg.sv
// Shared L1/L2 interface types: memory operation codes and the word server FSM states.
package xentry_pkg;
  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    STORE   = 2'd1,
    CLFLUSH = 2'd2
  } memory_operation_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } l2_server_state_e;
endpackage

// File: rtl/l2_word_server_if.sv
// L1 <-> L2 single-word request/response bus.
interface l2_word_server_if #(parameter int XLEN = 32) ();
   import xentry_pkg::*;

   logic              l2_req_valid;
   memory_operation_e l2_req_type;
   logic [XLEN-1:0]   l2_req_address;
   logic [XLEN-1:0]   l2_word_to_store;
   logic              l2_req_ready;
   logic              l2_resp_valid;
   logic [XLEN-1:0]   l2_fetched_word;
   logic              l2_error;

   modport master (
      output l2_req_valid, l2_req_type, l2_req_address, l2_word_to_store,
      input  l2_req_ready, l2_resp_valid, l2_fetched_word, l2_error
   );

   modport slave (
      input  l2_req_valid, l2_req_type, l2_req_address, l2_word_to_store,
      output l2_req_ready, l2_resp_valid, l2_fetched_word, l2_error
   );
endinterface

// File: rtl/l2_backing_ram.sv
// Single-port word array, synchronous write and registered read.
module l2_backing_ram #(
  parameter int XLEN      = 32,
  parameter int MEM_WORDS = 1024,
  parameter     INIT_FILE = "",
  localparam int AW       = $clog2(MEM_WORDS)
) (
  input  logic            clk,
  input  logic            we,
  input  logic            re,
  input  logic [AW-1:0]   addr,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] rdata
);
  logic [XLEN-1:0] mem [MEM_WORDS];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end
endmodule

// File: rtl/l2_word_server.sv
// Fixed-latency word responder for the L1 data cache's L2 port: loads, stores, flush acks.
module l2_word_server
   import xentry_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int MEM_WORDS = 1024,
   parameter int LATENCY   = 4,
   parameter     INIT_FILE = ""
) (
   input  logic            clk,
   input  logic            reset,
   l2_word_server_if.slave bus
);
   localparam int L2_WORD_INDEX_SIZE = $clog2(MEM_WORDS);
   localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [XLEN:0] MEM_BYTES = (XLEN+1)'(MEM_WORDS) << 2;

   generate
      if (LATENCY < 1) begin : g_latency_check
         $error("l2_word_server: LATENCY must be >= 1");
      end
   endgenerate

   l2_server_state_e  state, state_nxt;
   logic [CNT_W-1:0]  cnt;
   memory_operation_e type_q;
   logic [XLEN-1:0]   addr_q;
   logic [XLEN-1:0]   data_q;
   logic              fetch_sel;
   logic              err_q;
   logic              accept;
   logic              access;
   logic              illegal;
   logic [XLEN-1:0]   ram_rdata;

   assign accept  = bus.l2_req_valid && (state == IDLE);
   assign access  = (state == WAIT) && (cnt == '0);
   assign illegal = (addr_q[1:0] != 2'b00) || ({1'b0, addr_q} >= MEM_BYTES) ||
                    !(type_q inside {LOAD, STORE, CLFLUSH});

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.l2_req_valid) state_nxt = WAIT;
         WAIT:    if (cnt == '0) state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         type_q    <= LOAD;
         addr_q    <= '0;
         data_q    <= '0;
         fetch_sel <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            type_q <= bus.l2_req_type;
            addr_q <= bus.l2_req_address;
            data_q <= bus.l2_word_to_store;
            cnt    <= CNT_W'(LATENCY - 1);
         end else if ((state == WAIT) && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
         end
         // Output word tracks the RAM read register only after a legal load;
         // an illegal request forces zero, stores and flushes leave it alone.
         if (access) begin
            err_q <= illegal;
            if (illegal) fetch_sel <= 1'b0;
            else if (type_q == LOAD) fetch_sel <= 1'b1;
         end
      end
   end

   l2_backing_ram #(
      .XLEN(XLEN), .MEM_WORDS(MEM_WORDS), .INIT_FILE(INIT_FILE)
   ) u_ram (
      .clk   (clk),
      .we    (access && !illegal && (type_q == STORE)),
      .re    (access && !illegal && (type_q == LOAD)),
      .addr  (addr_q[L2_WORD_INDEX_SIZE+1:2]),
      .wdata (data_q),
      .rdata (ram_rdata)
   );

   assign bus.l2_req_ready    = (state == IDLE);
   assign bus.l2_resp_valid   = (state == RESP);
   assign bus.l2_fetched_word = fetch_sel ? ram_rdata : '0;
   assign bus.l2_error        = err_q;
endmodule

// File: tb/tb_l2_word_server.sv
// Directed + randomized bench for l2_word_server against a word-array reference model.
module tb_l2_word_server;
   import xentry_pkg::*;

   localparam int LAT = 4;
   localparam int MW  = 1024;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   l2_word_server_if #(.XLEN(32)) bus  ();
   l2_word_server_if #(.XLEN(32)) bus1 ();

   l2_word_server #(.XLEN(32), .MEM_WORDS(MW), .LATENCY(LAT)) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );
   l2_word_server #(.XLEN(32), .MEM_WORDS(MW), .LATENCY(1)) dut1 (
      .clk(clk), .reset(reset), .bus(bus1)
   );

   int compared = 0;
   int mismatched = 0;
   logic [31:0] mem_m [int];
   logic [31:0] last_w;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One full transaction: issue at a negedge, follow it to its response, check against the model.
   task automatic xact(input string tag, input logic [1:0] t, input logic [31:0] a,
                       input logic [31:0] d);
      logic legal;
      int lat, n;
      legal = (a[1:0] == 2'b00) && (a < MW*4) && (t != 2'd3);
      bus.l2_req_valid     = 1'b1;
      bus.l2_req_type      = memory_operation_e'(t);
      bus.l2_req_address   = a;
      bus.l2_word_to_store = d;
      n = 0;
      while (bus.l2_req_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      chk({tag, " ready_at_issue"}, 32'(bus.l2_req_ready), 32'd1);
      @(posedge clk); #1;
      bus.l2_req_valid = 1'b0;
      lat = 0;
      while (bus.l2_resp_valid !== 1'b1 && lat < LAT + 8) begin
         chk({tag, " ready_low"}, 32'(bus.l2_req_ready), 32'd0);
         @(posedge clk); #1;
         lat++;
      end
      chk({tag, " latency"}, 32'(lat), 32'(LAT));
      chk({tag, " ready_low_resp"}, 32'(bus.l2_req_ready), 32'd0);
      if (legal && t == 2'd1) mem_m[int'(a >> 2)] = d;
      if (!legal) last_w = 32'd0;
      else if (t == 2'd0 && mem_m.exists(int'(a >> 2))) last_w = mem_m[int'(a >> 2)];
      chk({tag, " error"}, 32'(bus.l2_error), 32'(!legal));
      if (!(legal && t == 2'd0 && !mem_m.exists(int'(a >> 2))))
         chk({tag, " word"}, bus.l2_fetched_word, last_w);
      @(posedge clk); #1;
      chk({tag, " pulse_end"}, 32'(bus.l2_resp_valid), 32'd0);
      chk({tag, " ready_back"}, 32'(bus.l2_req_ready), 32'd1);
      @(negedge clk);
   endtask

   initial begin
      logic seen;
      logic [31:0] a, d;
      logic [1:0] t;
      bus.l2_req_valid = 0; bus.l2_req_type = LOAD; bus.l2_req_address = 0; bus.l2_word_to_store = 0;
      bus1.l2_req_valid = 0; bus1.l2_req_type = LOAD; bus1.l2_req_address = 0; bus1.l2_word_to_store = 0;
      last_w = 32'd0;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst ready", 32'(bus.l2_req_ready), 32'd1);
      chk("rst resp", 32'(bus.l2_resp_valid), 32'd0);
      chk("rst word", bus.l2_fetched_word, 32'd0);
      chk("rst error", 32'(bus.l2_error), 32'd0);
      @(negedge clk); reset = 1'b0;

      xact("st40", 2'd1, 32'h40, 32'hDEADBEEF);
      xact("ld40", 2'd0, 32'h40, 32'h0);

      for (int i = 0; i < 8; i++) xact("fill_st", 2'd1, 32'h100 + 32'(4*i), 32'h40 + 32'(i));
      for (int i = 0; i < 8; i++) xact("fill_ld", 2'd0, 32'h100 + 32'(4*i), 32'h0);

      xact("misalign_ld", 2'd0, 32'h42, 32'h0);
      xact("oor_st", 2'd1, 32'(MW*4), 32'hBADBAD00);
      xact("bad_type", 2'd3, 32'h40, 32'h11111111);
      xact("ld40_again", 2'd0, 32'h40, 32'h0);

      xact("st80", 2'd1, 32'h80, 32'hCAFEF00D);
      xact("flush80", 2'd2, 32'h80, 32'h0);
      xact("ld80", 2'd0, 32'h80, 32'h0);

      // Reset two cycles into a STORE: it must not commit.
      xact("st20", 2'd1, 32'h20, 32'hA5A5A5A5);
      bus.l2_req_valid = 1'b1; bus.l2_req_type = STORE;
      bus.l2_req_address = 32'h20; bus.l2_word_to_store = 32'h12345678;
      @(posedge clk); #1;
      bus.l2_req_valid = 1'b0;
      @(posedge clk); #1;
      @(negedge clk); reset = 1'b1;
      @(posedge clk); #1;
      last_w = 32'd0;
      chk("midrst resp", 32'(bus.l2_resp_valid), 32'd0);
      chk("midrst ready", 32'(bus.l2_req_ready), 32'd1);
      chk("midrst word", bus.l2_fetched_word, 32'd0);
      @(negedge clk);
      bus.l2_req_valid = 1'b1; bus.l2_req_type = LOAD; bus.l2_req_address = 32'h40;
      @(posedge clk); #1;
      chk("rst_with_valid ready", 32'(bus.l2_req_ready), 32'd1);
      @(negedge clk); reset = 1'b0; bus.l2_req_valid = 1'b0;
      seen = 1'b0;
      repeat (LAT + 3) begin @(posedge clk); #1; if (bus.l2_resp_valid === 1'b1) seen = 1'b1; end
      chk("rst_with_valid no_resp", 32'(seen), 32'd0);
      @(negedge clk);
      xact("ld20_old", 2'd0, 32'h20, 32'h0);

      // Randomized traffic over a small pool of words plus illegal requests.
      for (int k = 0; k < 16; k++) xact("pool_st", 2'd1, 32'h200 + 32'(4*k), $urandom);
      for (int k = 0; k < 40; k++) begin
         a = 32'h200 + 32'(4 * $urandom_range(0, 15));
         d = $urandom;
         t = 2'($urandom_range(0, 3));
         case ($urandom_range(0, 7))
            0: a = a | 32'($urandom_range(1, 3));
            1: a = 32'(MW*4) + 32'(4 * $urandom_range(0, 255));
            default: ;
         endcase
         xact("rand", t, a, d);
      end

      // LATENCY=1 instance: accept at N, response at N+1, ready again at N+2.
      bus1.l2_req_valid = 1'b1; bus1.l2_req_type = STORE;
      bus1.l2_req_address = 32'h10; bus1.l2_word_to_store = 32'h0BADCAFE;
      @(posedge clk); #1;
      bus1.l2_req_valid = 1'b0;
      @(negedge clk);
      bus1.l2_req_valid = 1'b1; bus1.l2_req_type = LOAD;
      @(posedge clk); #1;
      chk("lat1 n+1 resp", 32'(bus1.l2_resp_valid), 32'd1);
      @(posedge clk); #1;
      chk("lat1 st ready", 32'(bus1.l2_req_ready), 32'd1);
      @(posedge clk); #1;
      bus1.l2_req_valid = 1'b0;
      chk("lat1 accept resp", 32'(bus1.l2_resp_valid), 32'd0);
      chk("lat1 accept ready", 32'(bus1.l2_req_ready), 32'd0);
      @(posedge clk); #1;
      chk("lat1 ld resp", 32'(bus1.l2_resp_valid), 32'd1);
      chk("lat1 ld word", bus1.l2_fetched_word, 32'h0BADCAFE);
      chk("lat1 ld ready", 32'(bus1.l2_req_ready), 32'd0);
      @(posedge clk); #1;
      chk("lat1 n+2 ready", 32'(bus1.l2_req_ready), 32'd1);
      chk("lat1 n+2 resp", 32'(bus1.l2_resp_valid), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
